// File: rtl/alu_stage.sv
// alu_stage: registered RV32I integer/branch/jump execution stage.
// Takes one issued op per cycle and drives the ALU CDB a cycle later.
package alu_pkg;
    typedef logic [31:0] data_t;
    typedef logic [4:0]  rob_pos_t;
    typedef logic [5:0]  openum_t;

    localparam rob_pos_t ZERO_ROB = 5'd0;

    localparam openum_t OP_NOP   = 6'd0;
    localparam openum_t OP_ADD   = 6'd1;
    localparam openum_t OP_SUB   = 6'd2;
    localparam openum_t OP_AND   = 6'd3;
    localparam openum_t OP_OR    = 6'd4;
    localparam openum_t OP_XOR   = 6'd5;
    localparam openum_t OP_SLL   = 6'd6;
    localparam openum_t OP_SRL   = 6'd7;
    localparam openum_t OP_SRA   = 6'd8;
    localparam openum_t OP_SLT   = 6'd9;
    localparam openum_t OP_SLTU  = 6'd10;
    localparam openum_t OP_ADDI  = 6'd11;
    localparam openum_t OP_ANDI  = 6'd12;
    localparam openum_t OP_ORI   = 6'd13;
    localparam openum_t OP_XORI  = 6'd14;
    localparam openum_t OP_SLTI  = 6'd15;
    localparam openum_t OP_SLTIU = 6'd16;
    localparam openum_t OP_SLLI  = 6'd17;
    localparam openum_t OP_SRLI  = 6'd18;
    localparam openum_t OP_SRAI  = 6'd19;
    localparam openum_t OP_LUI   = 6'd20;
    localparam openum_t OP_AUIPC = 6'd21;
    localparam openum_t OP_JAL   = 6'd22;
    localparam openum_t OP_JALR  = 6'd23;
    localparam openum_t OP_BEQ   = 6'd24;
    localparam openum_t OP_BNE   = 6'd25;
    localparam openum_t OP_BLT   = 6'd26;
    localparam openum_t OP_BGE   = 6'd27;
    localparam openum_t OP_BLTU  = 6'd28;
    localparam openum_t OP_BGEU  = 6'd29;

    typedef struct packed {
        data_t value;
        logic  jump;
        data_t target;
    } cdb_t;
endpackage

module alu_stage
    import alu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  openum_t  in_rs_op,
    input  data_t    in_rs_value1,
    input  data_t    in_rs_value2,
    input  data_t    in_rs_imm,
    input  data_t    in_rs_pc,
    input  rob_pos_t in_rs_rob_pos,
    input  logic     in_rob_xbp,
    output rob_pos_t out_cdb_pos,
    output data_t    out_cdb_value,
    output logic     out_cdb_jump,
    output data_t    out_cdb_target
);
    data_t v1;
    data_t v2;
    data_t imm;
    data_t pc4;
    data_t br_tgt;
    data_t jalr_sum;
    logic  lt_s;
    logic  lt_u;
    logic  lti_s;
    logic  lti_u;
    logic  valid;
    logic  bcast;
    cdb_t  res;

    assign v1       = in_rs_value1;
    assign v2       = in_rs_value2;
    assign imm      = in_rs_imm;
    assign pc4      = in_rs_pc + 32'd4;
    assign br_tgt   = in_rs_pc + imm;
    assign jalr_sum = v1 + imm;
    assign lt_s     = $signed(v1) < $signed(v2);
    assign lt_u     = v1 < v2;
    assign lti_s    = $signed(v1) < $signed(imm);
    assign lti_u    = v1 < imm;

    always_comb begin
        valid      = 1'b1;
        res.value  = '0;
        res.jump   = 1'b0;
        res.target = pc4;
        case (in_rs_op)
            OP_ADD:   res.value = v1 + v2;
            OP_SUB:   res.value = v1 - v2;
            OP_AND:   res.value = v1 & v2;
            OP_OR:    res.value = v1 | v2;
            OP_XOR:   res.value = v1 ^ v2;
            OP_SLL:   res.value = v1 << v2[4:0];
            OP_SRL:   res.value = v1 >> v2[4:0];
            OP_SRA:   res.value = $unsigned($signed(v1) >>> v2[4:0]);
            OP_SLT:   res.value = {31'd0, lt_s};
            OP_SLTU:  res.value = {31'd0, lt_u};
            OP_ADDI:  res.value = v1 + imm;
            OP_ANDI:  res.value = v1 & imm;
            OP_ORI:   res.value = v1 | imm;
            OP_XORI:  res.value = v1 ^ imm;
            OP_SLTI:  res.value = {31'd0, lti_s};
            OP_SLTIU: res.value = {31'd0, lti_u};
            OP_SLLI:  res.value = v1 << imm[4:0];
            OP_SRLI:  res.value = v1 >> imm[4:0];
            OP_SRAI:  res.value = $unsigned($signed(v1) >>> imm[4:0]);
            OP_LUI:   res.value = imm;
            OP_AUIPC: res.value = br_tgt;
            OP_JAL: begin
                res.value  = pc4;
                res.jump   = 1'b1;
                res.target = br_tgt;
            end
            OP_JALR: begin
                res.value  = pc4;
                res.jump   = 1'b1;
                res.target = {jalr_sum[31:1], 1'b0};
            end
            OP_BEQ:   res.jump = (v1 == v2);
            OP_BNE:   res.jump = (v1 != v2);
            OP_BLT:   res.jump = lt_s;
            OP_BGE:   res.jump = !lt_s;
            OP_BLTU:  res.jump = lt_u;
            OP_BGEU:  res.jump = !lt_u;
            default:  valid = 1'b0;
        endcase
        // Branch value stays zero; only the redirect matters to the ROB.
        if (res.jump && in_rs_op >= OP_BEQ && in_rs_op <= OP_BGEU) begin
            res.target = br_tgt;
        end
    end

    assign bcast = valid && (in_rs_rob_pos != ZERO_ROB);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_cdb_pos    <= ZERO_ROB;
            out_cdb_value  <= '0;
            out_cdb_jump   <= 1'b0;
            out_cdb_target <= '0;
        end else if (rdy) begin
            if (in_rob_xbp) begin
                out_cdb_pos  <= ZERO_ROB;
                out_cdb_jump <= 1'b0;
            end else if (bcast) begin
                out_cdb_pos    <= in_rs_rob_pos;
                out_cdb_value  <= res.value;
                out_cdb_jump   <= res.jump;
                out_cdb_target <= res.target;
            end else begin
                out_cdb_pos <= ZERO_ROB;
            end
        end
    end
endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: directed table, corner sequences and random ops
// checked against a behavioural RV32I model.
module tb_alu_stage;
    import alu_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    logic     rdy;
    logic     xbp;
    openum_t  op;
    data_t    v1;
    data_t    v2;
    data_t    imm;
    data_t    pc;
    rob_pos_t pos;
    rob_pos_t cdb_pos;
    data_t    cdb_value;
    logic     cdb_jump;
    data_t    cdb_target;

    alu_stage dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .in_rs_op       (op),
        .in_rs_value1   (v1),
        .in_rs_value2   (v2),
        .in_rs_imm      (imm),
        .in_rs_pc       (pc),
        .in_rs_rob_pos  (pos),
        .in_rob_xbp     (xbp),
        .out_cdb_pos    (cdb_pos),
        .out_cdb_value  (cdb_value),
        .out_cdb_jump   (cdb_jump),
        .out_cdb_target (cdb_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic  b;
        data_t v;
        logic  j;
        data_t t;
    } res_t;

    typedef struct {
        string    name;
        openum_t  op;
        data_t    v1;
        data_t    v2;
        data_t    imm;
        data_t    pc;
        rob_pos_t pos;
        data_t    ev;
        logic     ej;
        data_t    et;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    rob_pos_t e_pos;
    data_t    e_val;
    data_t    e_tgt;
    logic     e_jmp;
    logic     k_vt;
    logic     k_j;

    vec_t vt[17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic slt(input data_t a, input data_t b);
        return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    endfunction

    function automatic data_t sra(input data_t a, input logic [4:0] s);
        data_t fill;
        fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0;
        return (a >> s) | fill;
    endfunction

    function automatic res_t model(input openum_t o, input data_t a,
                                   input data_t b, input data_t i,
                                   input data_t p);
        res_t r;
        logic take;
        r.b  = 1'b1;
        r.v  = 32'd0;
        r.j  = 1'b0;
        r.t  = p + 32'd4;
        take = 1'b0;
        case (o)
            OP_ADD:   r.v = a + b;
            OP_SUB:   r.v = a + ~b + 32'd1;
            OP_AND:   r.v = a & b;
            OP_OR:    r.v = a | b;
            OP_XOR:   r.v = a ^ b;
            OP_SLL:   r.v = a << b[4:0];
            OP_SRL:   r.v = a >> b[4:0];
            OP_SRA:   r.v = sra(a, b[4:0]);
            OP_SLT:   r.v = {31'd0, slt(a, b)};
            OP_SLTU:  r.v = (a < b) ? 32'd1 : 32'd0;
            OP_ADDI:  r.v = a + i;
            OP_ANDI:  r.v = a & i;
            OP_ORI:   r.v = a | i;
            OP_XORI:  r.v = a ^ i;
            OP_SLTI:  r.v = {31'd0, slt(a, i)};
            OP_SLTIU: r.v = (a < i) ? 32'd1 : 32'd0;
            OP_SLLI:  r.v = a << i[4:0];
            OP_SRLI:  r.v = a >> i[4:0];
            OP_SRAI:  r.v = sra(a, i[4:0]);
            OP_LUI:   r.v = i;
            OP_AUIPC: r.v = p + i;
            OP_JAL: begin
                r.v = p + 32'd4;
                r.j = 1'b1;
                r.t = p + i;
            end
            OP_JALR: begin
                r.v = p + 32'd4;
                r.j = 1'b1;
                r.t = (a + i) & 32'hFFFF_FFFE;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                case (o)
                    OP_BEQ:  take = (a == b);
                    OP_BNE:  take = (a != b);
                    OP_BLT:  take = slt(a, b);
                    OP_BGE:  take = !slt(a, b);
                    OP_BLTU: take = (a < b);
                    default: take = !(a < b);
                endcase
                r.j = take;
                if (take) r.t = p + i;
            end
            default: r.b = 1'b0;
        endcase
        return r;
    endfunction

    task automatic set_in(input openum_t o, input data_t a, input data_t b,
                          input data_t i, input data_t p, input rob_pos_t t);
        op  = o;
        v1  = a;
        v2  = b;
        imm = i;
        pc  = p;
        pos = t;
    endtask

    task automatic tick();
        res_t r;
        r = model(op, v1, v2, imm, pc);
        if (rst) begin
            e_pos = ZERO_ROB;
            e_val = 32'd0;
            e_jmp = 1'b0;
            e_tgt = 32'd0;
            k_vt  = 1'b1;
            k_j   = 1'b1;
        end else if (rdy) begin
            if (xbp) begin
                e_pos = ZERO_ROB;
                e_jmp = 1'b0;
                k_j   = 1'b1;
                k_vt  = 1'b0;
            end else if (r.b && pos != ZERO_ROB) begin
                e_pos = pos;
                e_val = r.v;
                e_jmp = r.j;
                e_tgt = r.t;
                k_vt  = 1'b1;
                k_j   = 1'b1;
            end else begin
                e_pos = ZERO_ROB;
                k_vt  = 1'b0;
                k_j   = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("cdb_pos", cdb_pos, e_pos);
        if (k_j) chk("cdb_jump", cdb_jump, e_jmp);
        if (k_vt) begin
            chk("cdb_value", cdb_value, e_val);
            chk("cdb_target", cdb_target, e_tgt);
        end
    endtask

    initial begin
        vt[0]  = '{"add",   OP_ADD,   5, 7, 0, 32'h200, 3, 12, 0, 32'h204};
        vt[1]  = '{"sub",   OP_SUB,   0, 1, 0, 32'h200, 4,
                   32'hFFFF_FFFF, 0, 32'h204};
        vt[2]  = '{"sra",   OP_SRA,   32'h8000_0000, 4, 0, 32'h200, 5,
                   32'hF800_0000, 0, 32'h204};
        vt[3]  = '{"slt",   OP_SLT,   32'hFFFF_FFFF, 1, 0, 32'h200, 6,
                   1, 0, 32'h204};
        vt[4]  = '{"sltu",  OP_SLTU,  32'hFFFF_FFFF, 1, 0, 32'h200, 7,
                   0, 0, 32'h204};
        vt[5]  = '{"sltiu", OP_SLTIU, 5, 0, 32'hFFFF_FFFF, 32'h200, 8,
                   1, 0, 32'h204};
        vt[6]  = '{"blt",   OP_BLT,   32'hFFFF_FFFD, 2, 32'h20, 32'h100, 9,
                   0, 1, 32'h120};
        vt[7]  = '{"bgeu",  OP_BGEU,  32'hFFFF_FFFD, 2, 32'h20, 32'h100, 10,
                   0, 1, 32'h120};
        vt[8]  = '{"beq",   OP_BEQ,   4, 5, 32'h20, 32'h100, 11,
                   0, 0, 32'h104};
        vt[9]  = '{"jalr",  OP_JALR,  32'h1003, 0, 4, 32'h40, 12,
                   32'h44, 1, 32'h1006};
        vt[10] = '{"jal",   OP_JAL,   0, 0, 32'hFFFF_FFF8, 32'h40, 13,
                   32'h44, 1, 32'h38};
        vt[11] = '{"auipc", OP_AUIPC, 0, 0, 32'h1234_5000, 32'h1000, 14,
                   32'h1234_6000, 0, 32'h1004};
        vt[12] = '{"lui",   OP_LUI,   0, 0, 32'hABCD_E000, 32'h200, 15,
                   32'hABCD_E000, 0, 32'h204};
        vt[13] = '{"srai",  OP_SRAI,  32'h7FFF_FFF0, 0, 4, 32'h200, 16,
                   32'h07FF_FFFF, 0, 32'h204};
        vt[14] = '{"sll31", OP_SLL,   1, 32'h3F, 0, 32'h200, 17,
                   32'h8000_0000, 0, 32'h204};
        vt[15] = '{"addi_wrap", OP_ADDI, 32'hFFFF_FFFF, 0, 1, 32'h200, 18,
                   0, 0, 32'h204};
        vt[16] = '{"bne",   OP_BNE,   4, 5, 32'h20, 32'h100, 31,
                   0, 1, 32'h120};

        rst = 1'b1;
        rdy = 1'b1;
        xbp = 1'b0;
        k_vt = 1'b0;
        k_j  = 1'b0;
        e_pos = ZERO_ROB;
        e_val = 32'd0;
        e_jmp = 1'b0;
        e_tgt = 32'd0;
        set_in(OP_NOP, 0, 0, 0, 0, ZERO_ROB);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            set_in(vt[i].op, vt[i].v1, vt[i].v2, vt[i].imm, vt[i].pc,
                   vt[i].pos);
            tick();
            chk({vt[i].name, "_pos"}, cdb_pos, vt[i].pos);
            chk({vt[i].name, "_value"}, cdb_value, vt[i].ev);
            chk({vt[i].name, "_jump"}, cdb_jump, vt[i].ej);
            chk({vt[i].name, "_target"}, cdb_target, vt[i].et);
            set_in(OP_NOP, 0, 0, 0, 0, 3);
            tick();
            chk("nop_pos", cdb_pos, ZERO_ROB);
        end

        set_in(OP_ADD, 1, 2, 0, 0, 5);
        tick();
        chk("b2b_a", cdb_value, 3);
        set_in(OP_ADD, 10, 20, 0, 0, 5);
        tick();
        chk("b2b_b_pos", cdb_pos, 5);
        chk("b2b_b", cdb_value, 30);

        set_in(OP_ADD, 1, 1, 0, 0, ZERO_ROB);
        tick();
        chk("zero_tag", cdb_pos, ZERO_ROB);
        set_in(6'd45, 1, 1, 0, 0, 9);
        tick();
        chk("bad_op", cdb_pos, ZERO_ROB);

        set_in(OP_JAL, 0, 0, 8, 32'h80, 6);
        tick();
        set_in(OP_SUB, 9, 3, 0, 0, 7);
        xbp = 1'b1;
        #2;
        chk("flush_vis_pos", cdb_pos, 6);
        chk("flush_vis_jump", cdb_jump, 1);
        tick();
        chk("flush_pos", cdb_pos, ZERO_ROB);
        chk("flush_jump", cdb_jump, 0);
        xbp = 1'b0;
        set_in(OP_NOP, 0, 0, 0, 0, 7);
        tick();
        chk("post_flush", cdb_pos, ZERO_ROB);

        set_in(OP_ADDI, 100, 0, 5, 0, 7);
        tick();
        chk("addi_value", cdb_value, 105);
        set_in(OP_ADD, 1, 1, 0, 0, 9);
        rdy = 1'b0;
        repeat (3) begin
            tick();
            chk("hold_pos", cdb_pos, 7);
            chk("hold_value", cdb_value, 105);
        end
        rdy = 1'b1;
        tick();
        chk("resume_pos", cdb_pos, 9);
        chk("resume_value", cdb_value, 2);

        set_in(OP_ADD, 4, 4, 0, 0, 10);
        tick();
        set_in(OP_ADD, 5, 5, 0, 0, 11);
        rst = 1'b1;
        tick();
        chk("rst_mid_pos", cdb_pos, ZERO_ROB);
        chk("rst_mid_value", cdb_value, 0);
        rst = 1'b0;

        for (int n = 0; n < 600; n++) begin
            data_t a;
            data_t b;
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 40);
            set_in(openum_t'($urandom_range(0, 33)), a, b, $urandom(),
                   $urandom(), rob_pos_t'($urandom_range(0, 31)));
            rdy = ($urandom_range(0, 9) != 0);
            xbp = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_stage.md
# alu_stage

Registered integer execution stage directly downstream of the reservation station. Each cycle it takes at most one issued operation (op, operands, imm, pc, ROB tag), evaluates the RV32I integer/branch/jump semantics and drives the ALU CDB one cycle later. The ALU CDB feeds the ROB, the reservation station (operand wake-up) and the load/store buffer. A ROB misbranch flush squashes any in-flight result.

## Interface
- Parameters: none. Widths come from the shared definition header: `DATA_TYPE` is 32 bits, plus `ROB_POS_TYPE` and `OPENUM_TYPE`. `ZERO_ROB` means "no entry". `OPENUM_NOP` means "no operation".
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; when low the stage holds all state
- in_rs_op  in  OPENUM  issued op; `OPENUM_NOP` = no issue this cycle
- in_rs_value1  in  32  rs1 value
- in_rs_value2  in  32  rs2 value
- in_rs_imm  in  32  sign-extended immediate (already shifted for LUI/AUIPC)
- in_rs_pc  in  32  instruction pc
- in_rs_rob_pos  in  ROB_POS  destination ROB tag
- in_rob_xbp  in  1  misbranch flush
- out_cdb_pos  out  ROB_POS  broadcast tag; `ZERO_ROB` = no broadcast
- out_cdb_value  out  32  rd result
- out_cdb_jump  out  1  resolved control transfer taken
- out_cdb_target  out  32  resolved next pc

## Operation
- Computation is combinational from the in_rs_* inputs. All outputs are registered.
- Register-register ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - Shift amount is value2[4:0].
  - SRA is arithmetic; SLT is a signed compare.
- Immediate ops: ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI.
  - imm replaces value2; shift amount is imm[4:0].
  - SLTIU compares unsigned against the sign-extended imm.
- LUI: value = imm. AUIPC: value = pc + imm.
- JAL: value = pc+4; jump=1; target = pc+imm.
- JALR: value = pc+4; jump=1; target = (value1+imm) & ~1.
- Branches (BEQ, BNE, BLT, BGE, BLTU, BGEU):
  - value = 0.
  - jump = condition result.
  - target = pc+imm if taken, else pc+4.
  - The ROB ignores value for branches.
- Non-control ops: jump=0, target=pc+4.
- All adds wrap modulo 2^32; there is no overflow trap.
- Unknown/unsupported op: treated as NOP, so no broadcast.
- Op with in_rs_rob_pos == `ZERO_ROB`: no broadcast.

## Timing
- Reset values: out_cdb_pos=`ZERO_ROB`, out_cdb_value=0, out_cdb_jump=0, out_cdb_target=0.
- Latency is 1 cycle. An op presented in cycle N appears on the CDB for exactly cycle N+1, provided rdy is high at the edge ending cycle N.
- Throughput is 1 op/cycle. There is no backpressure; the stage is always ready.
- out_cdb_pos returns to `ZERO_ROB` in any cycle after a NOP input. value, jump and target hold their last values and are don't-care while pos is `ZERO_ROB`.
- Flush:
  - in_rob_xbp=1 at an edge forces out_cdb_pos=`ZERO_ROB` and jump=0, and discards the input op of that cycle.
  - A result already on the CDB in the flush cycle is still visible that cycle; consumers gate it with xbp.
- rdy low: all outputs hold. The same broadcast stays visible and is not re-counted by this stage. Consumers also stall.
- rst has priority over rdy and xbp. Reset mid-stream drops the pending result.
- Back-to-back ops with the same ROB tag are legal. Each produces its own broadcast cycle.

## Test plan
- Reset, then ADD, v1=5, v2=7, rob=3 -> next cycle pos=3, value=12. The cycle after (NOP) -> pos=`ZERO_ROB`.
- SUB 0-1 -> 0xFFFFFFFF. SRA 0x80000000 by 4 -> 0xF8000000. SLT(-1,1)=1. SLTU(0xFFFFFFFF,1)=0. SLTIU with imm=-1, v1=5 -> 1.
- BLT pc=0x100, imm=0x20, v1=-3, v2=2 -> jump=1, target=0x120. BGEU same operands -> jump=1, target=0x120. BEQ 4,5 -> jump=0, target=0x104.
- JALR pc=0x40, v1=0x1003, imm=4 -> value=0x44, jump=1, target=0x1006. JAL pc=0x40, imm=-8 -> target=0x38.
- Back-to-back ops, then xbp with an op presented -> that op never broadcasts; the following cycle shows pos=`ZERO_ROB`, jump=0.
- rdy low for 3 cycles after an ADDI broadcast -> pos/value held. An op presented while rdy is low is not captured until rdy returns high.
